// File: rtl/str_pkg.sv
// Shared definitions for the string transmit/receive pair: FSM states,
// default terminator and the reference string.
package str_pkg;

   typedef enum logic [1:0] {
      COLLECT,
      DONE,
      DRAIN,
      GAP
   } state_t;

   localparam logic [7:0]       TERM_DEFAULT = 8'h0D;
   localparam int unsigned      EXP_LEN      = 12;
   localparam logic [8*12-1:0]  EXPECTED     = "Hello spence";

   // Byte i of EXPECTED, counting from the first character.
   function automatic logic [7:0] exp_byte(input int unsigned i);
      if (i < EXP_LEN) return EXPECTED[8*(EXP_LEN-1-i) +: 8];
      return 8'h00;
   endfunction

endpackage

// File: rtl/str_receiver_if.sv
// Byte-in / replay-out bundle of the string receiver.
// master = UART receiver plus downstream consumer, slave = str_receiver.
interface str_receiver_if;

   logic [7:0] in;
   logic       in_en;
   logic       consumer_ready;
   logic [7:0] out;
   logic       out_en;
   logic       str_done;
   logic [3:0] str_len;
   logic       dropped;
   logic       match;

   modport master (
      output in, in_en, consumer_ready,
      input  out, out_en, str_done, str_len, dropped, match
   );

   modport slave (
      input  in, in_en, consumer_ready,
      output out, out_en, str_done, str_len, dropped, match
   );

endinterface

// File: rtl/str_match.sv
// Combinational comparator: eq is set when the buffer is full and holds
// exactly the reference string.
module str_match
   import str_pkg::*;
#(
   parameter int unsigned DEPTH = 12
) (
   input  logic [7:0] mem [DEPTH],
   input  logic [3:0] len,
   output logic       eq
);

   always_comb begin
      eq = (DEPTH == EXP_LEN) && (len == 4'(DEPTH));
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (mem[i] != exp_byte(i)) eq = 1'b0;
      end
   end

endmodule

// File: rtl/str_receiver.sv
// Line collector: buffers bytes until TERM or full, pulses str_done, then
// replays the line under consumer_ready. Optional comparator: STR_RECEIVER_MATCH_EN.
module str_receiver
   import str_pkg::*;
#(
   parameter int unsigned DEPTH = 12,
   parameter logic [7:0]  TERM  = TERM_DEFAULT
) (
   input logic           clk,
   input logic           reset,
   str_receiver_if.slave bus
);

   localparam int unsigned IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  DEPTH4 = 4'(DEPTH);

   state_t     state_q, state_d;
   logic [3:0] count_q, count_d;
   logic [3:0] idx_q, idx_d;
   logic [7:0] out_q, out_d;
   logic       out_en_q, out_en_d;
   logic       str_done_q, str_done_d;
   logic [3:0] str_len_q, str_len_d;
   logic       dropped_q, dropped_d;
   logic       wr_en;
   logic [7:0] mem_q [DEPTH];

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      idx_d      = idx_q;
      out_d      = out_q;
      out_en_d   = 1'b0;
      str_done_d = 1'b0;
      str_len_d  = str_len_q;
      dropped_d  = dropped_q;
      wr_en      = 1'b0;

      case (state_q)
         COLLECT: begin
            if (bus.in_en) begin
               if (bus.in != TERM) begin
                  wr_en   = 1'b1;
                  count_d = count_q + 4'd1;
                  if (count_d == DEPTH4) begin
                     state_d    = DONE;
                     str_done_d = 1'b1;
                     str_len_d  = count_d;
                  end
               end else if (count_q != '0) begin
                  state_d    = DONE;
                  str_done_d = 1'b1;
                  str_len_d  = count_q;
               end
            end
         end
         DONE: begin
            state_d = DRAIN;
            idx_d   = '0;
         end
         DRAIN: begin
            if (idx_q == str_len_q) begin
               state_d = COLLECT;
               count_d = '0;
            end else if (bus.consumer_ready) begin
               out_d    = mem_q[idx_q[IW-1:0]];
               out_en_d = 1'b1;
               idx_d    = idx_q + 4'd1;
               state_d  = GAP;
            end
         end
         GAP: state_d = DRAIN;
         default: state_d = COLLECT;
      endcase

      if (bus.in_en && state_q != COLLECT) dropped_d = 1'b1;
   end

   // str_done/str_len are registered with the DONE transition, so they are
   // visible for exactly the cycle the FSM spends in DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= COLLECT;
         count_q    <= '0;
         idx_q      <= '0;
         out_q      <= '0;
         out_en_q   <= 1'b0;
         str_done_q <= 1'b0;
         str_len_q  <= '0;
         dropped_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         idx_q      <= idx_d;
         out_q      <= out_d;
         out_en_q   <= out_en_d;
         str_done_q <= str_done_d;
         str_len_q  <= str_len_d;
         dropped_q  <= dropped_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[count_q[IW-1:0]] <= bus.in;
      end
   end

   assign bus.out      = out_q;
   assign bus.out_en   = out_en_q;
   assign bus.str_done = str_done_q;
   assign bus.str_len  = str_len_q;
   assign bus.dropped  = dropped_q;

`ifdef STR_RECEIVER_MATCH_EN
   logic eq;

   str_match #(.DEPTH(DEPTH)) u_match (
      .mem (mem_q),
      .len (str_len_q),
      .eq  (eq)
   );

   assign bus.match = str_done_q & eq;
`else
   assign bus.match = 1'b0;
`endif

endmodule

// File: tb/tb_str_receiver.sv
// Directed bench for str_receiver: per-cycle vector table plus hand-written
// sequences for full buffer, back-pressure with drop, and reset mid-drain.
module tb_str_receiver;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   str_receiver_if bus_if ();

   str_receiver #(.DEPTH(12), .TERM(8'h0D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

`ifdef STR_RECEIVER_MATCH_EN
   localparam logic EXP_MATCH_FULL = 1'b1;
`else
   localparam logic EXP_MATCH_FULL = 1'b0;
`endif

   typedef struct {
      logic [7:0] in;
      logic       in_en;
      logic       ready;
      logic       exp_out_en;
      logic [7:0] exp_out;
      logic       exp_done;
      logic [3:0] exp_len;
   } vec_t;

   vec_t vecs [17];
   string hello = "Hello spence";

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic [7:0] b, input logic en, input logic rdy);
      bus_if.in             = b;
      bus_if.in_en          = en;
      bus_if.consumer_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int t;
      int last;
      int n;

      // in, en, rdy | out_en, out, done, len  (outputs seen after the edge)
      vecs[0]  = '{8'h0D, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0}; // empty line ignored
      vecs[1]  = '{8'h48, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0};
      vecs[2]  = '{8'h69, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0};
      vecs[3]  = '{8'h0D, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 4'd2};
      vecs[4]  = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'd2};
      vecs[5]  = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h48, 1'b0, 4'd2};
      vecs[6]  = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h48, 1'b0, 4'd2};
      vecs[7]  = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h69, 1'b0, 4'd2};
      vecs[8]  = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h69, 1'b0, 4'd2};
      vecs[9]  = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h69, 1'b0, 4'd2}; // back in COLLECT
      vecs[10] = '{8'h41, 1'b1, 1'b1, 1'b0, 8'h69, 1'b0, 4'd2};
      vecs[11] = '{8'h0D, 1'b1, 1'b1, 1'b0, 8'h69, 1'b1, 4'd1};
      vecs[12] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h69, 1'b0, 4'd1};
      vecs[13] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 4'd1};
      vecs[14] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h41, 1'b0, 4'd1};
      vecs[15] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h41, 1'b0, 4'd1};
      vecs[16] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h41, 1'b0, 4'd1};

      reset = 1'b1;
      step(8'h00, 1'b0, 1'b0);
      step(8'h00, 1'b0, 1'b0);
      check("reset_out", 16'(bus_if.out), 16'h0);
      check("reset_out_en", 16'(bus_if.out_en), 16'h0);
      check("reset_done", 16'(bus_if.str_done), 16'h0);
      check("reset_len", 16'(bus_if.str_len), 16'h0);
      check("reset_dropped", 16'(bus_if.dropped), 16'h0);
      check("reset_match", 16'(bus_if.match), 16'h0);
      reset = 1'b0;

      for (int i = 0; i < 17; i++) begin
         step(vecs[i].in, vecs[i].in_en, vecs[i].ready);
         check($sformatf("v%0d_out_en", i), 16'(bus_if.out_en), 16'(vecs[i].exp_out_en));
         check($sformatf("v%0d_out", i), 16'(bus_if.out), 16'(vecs[i].exp_out));
         check($sformatf("v%0d_done", i), 16'(bus_if.str_done), 16'(vecs[i].exp_done));
         check($sformatf("v%0d_len", i), 16'(bus_if.str_len), 16'(vecs[i].exp_len));
         check($sformatf("v%0d_match", i), 16'(bus_if.match), 16'h0);
         check($sformatf("v%0d_dropped", i), 16'(bus_if.dropped), 16'h0);
      end

      // Full buffer without terminator
      for (int i = 0; i < 12; i++) begin
         step(hello[i], 1'b1, 1'b1);
         if (i < 11) check("full_early_done", 16'(bus_if.str_done), 16'h0);
      end
      check("full_done", 16'(bus_if.str_done), 16'h1);
      check("full_len", 16'(bus_if.str_len), 16'd12);
      check("full_match", 16'(bus_if.match), 16'(EXP_MATCH_FULL));
      t = 0;
      last = 0;
      n = 0;
      while (n < 12 && t < 60) begin
         step(8'h00, 1'b0, 1'b1);
         t++;
         if (bus_if.out_en) begin
            check($sformatf("full_byte%0d", n), 16'(bus_if.out), 16'(hello[n]));
            check($sformatf("full_gap%0d", n), 16'(t - last), 16'd2);
            last = t;
            n++;
         end
      end
      check("full_count", 16'(n), 16'd12);
      step(8'h00, 1'b0, 1'b1);
      step(8'h00, 1'b0, 1'b1);
      check("full_dropped", 16'(bus_if.dropped), 16'h0);

      // Back-pressure with a byte arriving during the wait
      step(8'h41, 1'b1, 1'b0);
      step(8'h42, 1'b1, 1'b0);
      step(8'h0D, 1'b1, 1'b0);
      check("bp_done", 16'(bus_if.str_done), 16'h1);
      check("bp_len", 16'(bus_if.str_len), 16'd2);
      check("bp_match", 16'(bus_if.match), 16'h0);
      for (int i = 0; i < 10; i++) begin
         step(8'h55, (i == 3), 1'b0);
         check($sformatf("bp_hold%0d", i), 16'(bus_if.out_en), 16'h0);
         if (i == 3) check("bp_dropped_set", 16'(bus_if.dropped), 16'h1);
      end
      step(8'h00, 1'b0, 1'b1);
      check("bp_first_en", 16'(bus_if.out_en), 16'h1);
      check("bp_first_out", 16'(bus_if.out), 16'h41);
      for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b1);
      check("bp_dropped_sticky", 16'(bus_if.dropped), 16'h1);
      check("bp_last_out", 16'(bus_if.out), 16'h42);

      // Reset after 3 of 5 replayed bytes
      step(8'h31, 1'b1, 1'b1);
      step(8'h32, 1'b1, 1'b1);
      step(8'h33, 1'b1, 1'b1);
      step(8'h34, 1'b1, 1'b1);
      step(8'h35, 1'b1, 1'b1);
      step(8'h0D, 1'b1, 1'b1);
      check("rst_len5", 16'(bus_if.str_len), 16'd5);
      n = 0;
      t = 0;
      while (n < 3 && t < 30) begin
         step(8'h00, 1'b0, 1'b1);
         t++;
         if (bus_if.out_en) n++;
      end
      check("rst_three_seen", 16'(n), 16'd3);
      check("rst_third_byte", 16'(bus_if.out), 16'h33);
      reset = 1'b1;
      step(8'h00, 1'b0, 1'b1);
      reset = 1'b0;
      check("rst_out", 16'(bus_if.out), 16'h0);
      check("rst_out_en", 16'(bus_if.out_en), 16'h0);
      check("rst_done", 16'(bus_if.str_done), 16'h0);
      check("rst_len", 16'(bus_if.str_len), 16'h0);
      check("rst_dropped", 16'(bus_if.dropped), 16'h0);
      check("rst_match", 16'(bus_if.match), 16'h0);
      step(8'h5A, 1'b1, 1'b1);
      step(8'h0D, 1'b1, 1'b1);
      check("post_done", 16'(bus_if.str_done), 16'h1);
      check("post_len", 16'(bus_if.str_len), 16'd1);
      step(8'h00, 1'b0, 1'b1);
      step(8'h00, 1'b0, 1'b1);
      check("post_out_en", 16'(bus_if.out_en), 16'h1);
      check("post_out", 16'(bus_if.out), 16'h5A);
      check("post_dropped", 16'(bus_if.dropped), 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/str_receiver.md
# str_receiver

Receive-side string collector, the counterpart of the transmit-side string controller. Sits between the UART receiver FSM and downstream logic. Assembles incoming bytes into a line buffer until a terminator byte arrives or the buffer fills, flags completion, then replays the stored string one byte at a time under a ready handshake. The replay handshake is the same byte-plus-enable pulse used on the transmit side.

## Interface
- DEPTH, 12, buffer size in bytes; legal range 1..15.
- TERM, 8'h0D, terminator byte; never stored.
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  8  received byte from the UART receiver FSM.
- in_en  input  1  one-cycle strobe; `in` is valid this cycle.
- consumer_ready  input  1  downstream can take a replayed byte.
- out  output  8  replayed byte; registered.
- out_en  output  1  one-cycle pulse; `out` is valid.
- str_done  output  1  one-cycle pulse; a string is complete.
- str_len  output  4  stored length; valid from `str_done` until the next `str_done`.
- dropped  output  1  sticky flag; a byte arrived while not in COLLECT. Cleared only by reset.
- match  output  1  pulses with `str_done` when the string equals EXPECTED (see Configuration).

## Operation
- Reset:
  - state = COLLECT, count = 0.
  - buffer cleared to 0.
  - `out`, `out_en`, `str_done`, `str_len`, `dropped` and `match` all = 0.
  - Reset wins over every other event in every state, including mid-collect and mid-drain.
- **COLLECT**:
  - in_en with in != TERM → store `in` at buf[count], count+1. If the new count == DEPTH → DONE (buffer full; no terminator needed).
  - in_en with in == TERM and count > 0 → DONE; the terminator is not stored.
  - in_en with in == TERM and count == 0 → ignored (empty line); stay in COLLECT.
- **DONE**:
  - `str_done` = 1 and `str_len` = count for exactly this cycle's output.
  - Next state DRAIN, with idx = 0.
- **DRAIN**:
  - idx == str_len → return to COLLECT, count = 0.
  - Otherwise, if consumer_ready → next cycle `out` = buf[idx] and `out_en` = 1, idx+1, next state GAP.
  - Otherwise hold.
- **GAP**: one idle cycle with `out_en` = 0, then back to DRAIN. This guarantees at least one cycle between `out_en` pulses.
- in_en seen in DONE, DRAIN or GAP: the byte is discarded and `dropped` is set to 1.
- `out` holds its last value between pulses and is 0 after reset.
- Arithmetic: count and idx are 4 bits and never wrap, because DEPTH ≤ 15.

## Timing
- Terminator sampled at edge k:
  - `str_done` (and `match`) high during cycle k+1.
  - DRAIN entered at k+2.
  - First `out_en` at k+3 if consumer_ready is high at k+2.
- Full-buffer case: same timing, measured from the edge that samples the DEPTH-th byte.
- Sustained replay rate: one byte per 2 cycles with consumer_ready held high.
- consumer_ready dropping: takes effect at the next DRAIN sample; a pulse already issued is not retracted.
- Last byte: after `out_en` for the final byte, GAP then DRAIN detects idx == str_len. COLLECT is re-entered 2 cycles after the final `out_en` edge, and a byte is accepted from then on.

## Configuration
- Macro: `STR_RECEIVER_MATCH_EN`.
  - **Defined:** a comparator checks the stored string against EXPECTED. `match` = 1 together with `str_done` only when str_len == DEPTH and every byte is equal.
  - **Undefined:** no comparator logic is built and `match` is tied to 0. The port is present in both builds.

## Structure
- Shared package `str_pkg` holds:
  - state encodings: COLLECT, DONE, DRAIN, GAP.
  - the default TERM.
  - the EXPECTED constant, "Hello spence" (12 bytes), shared with the transmit-side controller.
- Sub-module: `str_match`, a combinational byte-wise comparator over the buffer. It is instantiated only under `STR_RECEIVER_MATCH_EN`.

## Test plan
- Send "Hi" then 0x0D with consumer_ready = 1:
  - `str_done` pulse with `str_len` = 2.
  - `out_en` pulses carry 0x48 then 0x69, two cycles apart.
  - Back in COLLECT afterwards.
- Send 12 bytes of "Hello spence" with no terminator:
  - `str_done` on the cycle after the 12th strobe, `str_len` = 12.
  - `match` = 1 with the macro defined, 0 without.
  - All 12 bytes replayed in order.
- Send 0x0D alone → no `str_done`; state stays in COLLECT; a following "A" plus 0x0D yields `str_len` = 1 and `out` = 0x41.
- Hold consumer_ready = 0 for 10 cycles after `str_done`, and send a byte during that window:
  - no `out_en` while ready is low.
  - `dropped` = 1 and stays 1.
  - replay starts 1 cycle after ready rises.
- Assert reset mid-drain after 3 of 5 bytes → next cycle all outputs are 0, `dropped` = 0, and a new string collects from index 0.
